// File: rtl/if_fetch_queue_if.sv
// Fetch-to-decode bus for if_fetch_queue.
// Carries the decode handshake (if_* head entry, id_ready), fetch control
// (fetch_en, redirect_valid, redirect_pc), and the combinational instruction
// memory port (fetch_pc out, mem_inst back).
//   master : the fetch stage (drives head entry, fetch_pc, count)
//   slave  : the decode / memory side
interface if_fetch_queue_if #(
  parameter int unsigned WORD      = 64,
  parameter int unsigned INST_SIZE = 32,
  parameter int unsigned DEPTH     = 4
);
  logic                   fetch_en;
  logic                   redirect_valid;
  logic [WORD-1:0]        redirect_pc;
  logic                   id_ready;
  logic                   if_valid;
  logic [WORD-1:0]        if_pc;
  logic [WORD-1:0]        if_pc_incr;
  logic [INST_SIZE-1:0]   if_inst;
  logic [WORD-1:0]        fetch_pc;
  logic [$clog2(DEPTH):0] count;
  logic [INST_SIZE-1:0]   mem_inst;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, id_ready, mem_inst,
    output if_valid, if_pc, if_pc_incr, if_inst, fetch_pc, count
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, id_ready, mem_inst,
    input  if_valid, if_pc, if_pc_incr, if_inst, fetch_pc, count
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry {pc, inst} FIFO.
// Owns the fetch PC, presents it to the combinational instruction memory,
// pushes fetched pairs into the FIFO and hands the head entry to decode
// through a valid/ready handshake. A redirect flushes the FIFO and restarts
// fetch at the (word-aligned) target.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : if_fetch_queue_if.master (handshake, control, memory port)
module if_fetch_queue #(
  parameter int unsigned    WORD      = 64,
  parameter int unsigned    INST_SIZE = 32,
  parameter int unsigned    DEPTH     = 4,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_n,
  if_fetch_queue_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [WORD-1:0]      pc_mem   [DEPTH];
  logic [INST_SIZE-1:0] inst_mem [DEPTH];

  logic [WORD-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            head_valid, full, push, pop;
  logic [WORD-1:0] redir_pc;

  assign head_valid = (count_q != '0);
  assign full       = (count_q == DepthC);
  assign redir_pc   = bus.redirect_pc & ~WORD'(3);

  always_comb begin
    pop  = head_valid & bus.id_ready & ~bus.redirect_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push = bus.fetch_en & ~bus.redirect_valid & (~full | pop);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = redir_pc;
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_d       = wr_q + PtrW'(1);
        fetch_pc_d = fetch_pc_q + WORD'(4);
      end
      if (pop) begin
        rd_d = rd_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]   <= fetch_pc_q;
      inst_mem[wr_q] <= bus.mem_inst;
    end
  end

  always_comb begin
    bus.if_valid   = head_valid;
    bus.if_pc      = '0;
    bus.if_pc_incr = '0;
    bus.if_inst    = '0;
    if (head_valid) begin
      bus.if_pc      = pc_mem[rd_q];
      bus.if_pc_incr = pc_mem[rd_q] + WORD'(4);
      bus.if_inst    = inst_mem[rd_q];
    end
  end

  assign bus.fetch_pc = fetch_pc_q;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic clk;
  logic rst_n;
  logic [31:0] img [256];

  if_fetch_queue_if #(.WORD(64), .INST_SIZE(32), .DEPTH(DEPTH)) bus ();

  if_fetch_queue #(
    .WORD(64), .INST_SIZE(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational instruction memory image, indexed by word address.
  assign bus.mem_inst = img[bus.fetch_pc[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of fetched PCs plus the fetch PC.
  logic [63:0] mq [$];
  logic [63:0] mpc;

  function automatic logic [31:0] img_of(input logic [63:0] pc);
    return img[pc[9:2]];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic v;
    v = (mq.size() != 0);
    chk("if_valid", 64'(bus.if_valid), 64'(v));
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("fetch_pc", bus.fetch_pc, mpc);
    if (v) begin
      chk("if_pc", bus.if_pc, mq[0]);
      chk("if_pc_incr", bus.if_pc_incr, mq[0] + 64'd4);
      chk("if_inst", 64'(bus.if_inst), 64'(img_of(mq[0])));
    end else begin
      chk("if_pc_idle", bus.if_pc, 64'd0);
      chk("if_pc_incr_idle", bus.if_pc_incr, 64'd0);
      chk("if_inst_idle", 64'(bus.if_inst), 64'd0);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = RESET_PC;
  endtask

  // Called at a negedge: drive inputs, let one rising edge happen, update the
  // model, then compare at the following negedge.
  task automatic step(input logic fe, input logic rv, input logic [63:0] rp, input logic ir);
    logic pop, push;
    bus.fetch_en       = fe;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.id_ready       = ir;
    @(posedge clk);
    if (rst_n) begin
      if (rv) begin
        mq.delete();
        mpc = {rp[63:2], 2'b00};
      end else begin
        pop  = (mq.size() != 0) && ir;
        push = fe && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back(mpc);
          mpc = mpc + 64'd4;
        end
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.fetch_en = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare();
  endtask

  initial begin
    logic [63:0] rp;
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    rst_n = 1'b0;
    bus.fetch_en = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b0;
    model_reset();

    // Streaming from reset with decode always ready.
    do_reset();
    chk("rst_valid_lit", 64'(bus.if_valid), 64'd0);
    chk("rst_fetch_pc_lit", bus.fetch_pc, 64'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      chk("stream_pc_lit", bus.if_pc, 64'(4 * i));
      chk("stream_inst_lit", 64'(bus.if_inst), 64'(img[i]));
      chk("stream_count_lit", 64'(bus.count), 64'd1);
    end

    // Decode stalled: fill to DEPTH, then drain in order.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);
    chk("stall_count_lit", 64'(bus.count), 64'd4);
    chk("stall_fetch_pc_lit", bus.fetch_pc, 64'd16);
    chk("stall_head_lit", bus.if_pc, 64'd0);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("full_pop_push_count_lit", 64'(bus.count), 64'd4);
    chk("full_pop_push_fpc_lit", bus.fetch_pc, 64'd20);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_pc_lit", bus.if_pc, 64'(4 * i));
      step(1'b1, 1'b0, '0, 1'b1);
    end

    // Redirect with 3 entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    chk("pre_redir_count_lit", 64'(bus.count), 64'd3);
    step(1'b1, 1'b1, 64'h103, 1'b0);
    chk("redir_count_lit", 64'(bus.count), 64'd0);
    chk("redir_valid_lit", 64'(bus.if_valid), 64'd0);
    chk("redir_fpc_lit", bus.fetch_pc, 64'h100);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("redir_head_lit", bus.if_pc, 64'h100);

    // fetch_en low drains the queue; redirect still applies with fetch_en low.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("drain_count_lit", 64'(bus.count), 64'd0);
    chk("drain_fpc_lit", bus.fetch_pc, 64'h104);
    step(1'b0, 1'b1, 64'h22, 1'b1);
    chk("redir_noen_fpc_lit", bus.fetch_pc, 64'h20);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("redir_noen_hold_lit", bus.fetch_pc, 64'h20);

    // Back-to-back redirects: the later one wins.
    step(1'b1, 1'b1, 64'h40, 1'b1);
    step(1'b1, 1'b1, 64'h80, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("b2b_head_lit", bus.if_pc, 64'h80);

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_valid_lit", 64'(bus.if_valid), 64'd0);
    chk("async_count_lit", 64'(bus.count), 64'd0);
    chk("async_fpc_lit", bus.fetch_pc, RESET_PC);
    @(negedge clk);
    step(1'b1, 1'b0, '0, 1'b1);
    rst_n = 1'b1;
    #1;
    compare();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, rp,
           $urandom_range(0, 9) < 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
